binary_to_bcd_sequential: RTL and testbench
===========================================

BINARY_TO_BCD_SEQUENTIAL -- requirements
Module: binary_to_bcd_sequential

Interface
REQ-001 Parameter BIN_W, default 8: binary input width; legal range 1..9, so that the maximum input of 511 fits three BCD digits.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  conversion request, sampled on rising edge of clk.
REQ-005 bin  input  BIN_W  unsigned binary value, captured on the accepting edge.
REQ-006 busy  output  1  high while a conversion is in progress or completing (states SHIFT and DONE).
REQ-007 done  output  1  single-cycle pulse marking a new result on bcd.
REQ-008 bcd  output  12  registered result: [11:8] hundreds, [7:4] tens, [3:0] ones; every digit SHALL be 0..9 and directly consumable by the downstream BCD-to-Excess-3 stage.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-010 IDLE with start=1 at an edge: capture bin into the shift register, clear the 12-bit working BCD register and the bit counter, go to SHIFT.
REQ-011 IDLE with start=0: remain in IDLE; bcd holds its value.
REQ-012 Each SHIFT edge: add 3 to every working digit >= 5 (all digits in parallel), then shift {working, shift_reg} left by 1 (MSB of shift_reg enters working bit 0), then increment the counter.
REQ-013 After the BIN_W-th shift edge: load bcd with the post-shift working value, assert done, go to DONE.
REQ-014 DONE: deassert done on the next edge and return to IDLE unconditionally; done SHALL be high for exactly one cycle.
REQ-015 Latency: done SHALL be high in the cycle following the edge that occurs BIN_W cycles after the accepting edge; start-to-start throughput SHALL be BIN_W+2 cycles.
REQ-016 start SHALL be ignored in SHIFT and DONE; bin changes after the accepting edge SHALL NOT affect the result.
REQ-017 start held continuously high SHALL yield back-to-back conversions, each accepted on the first IDLE edge.
REQ-018 bcd SHALL change only on the edge that asserts done (or on reset), and SHALL hold the previous result throughout a conversion.
REQ-019 The counter SHALL be ceil(log2(BIN_W+1)) bits wide; the working register SHALL never exceed 12 bits.
REQ-020 The result SHALL equal the decimal value of bin for all 2^BIN_W inputs.

Reset
REQ-021 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, bcd=12'h000, and clear the counter, working and shift registers.
REQ-022 rst SHALL take priority over start and over every state transition.
REQ-023 A reset mid-conversion SHALL abort it with no done pulse and no partial result on bcd; a start in the first cycle after rst is released SHALL be accepted normally.

Verification
REQ-024 BIN_W=8; bin=0, start pulse -> after 8 cycles, done pulse with bcd=12'h000; busy high for 9 cycles.
REQ-025 BIN_W=8; bin=255 -> bcd=12'h255; bin=99 -> bcd=12'h099; bin=10 -> bcd=12'h010; exhaustive sweep 0..255 matches the reference model.
REQ-026 start held high, bin=200 then 37 -> done pulses 10 cycles apart with bcd=12'h200 then 12'h037.
REQ-027 bin=200 accepted; rst asserted on the 4th SHIFT cycle -> busy=0, bcd=12'h000, no done pulse.
REQ-028 bin=123 accepted; start=1 with bin=45 during SHIFT -> request ignored; result 12'h123.
REQ-029 BIN_W=9; bin=511 -> bcd=12'h511 after 9 cycles.

Source files
------------

// File: rtl/binary_to_bcd_sequential.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_sequential
//
// Converts an unsigned binary value of up to 9 bits into three BCD digits
// using the shift-and-add-3 (double dabble) algorithm. The conversion
// processes one input bit per clock.
//
// Timing, for BIN_W = 8:
//   - The accepting edge is followed by BIN_W shift edges.
//   - The result appears on bcd, with a one-cycle done pulse, after the
//     last shift edge.
//   - The next request can be accepted BIN_W+2 cycles after the previous
//     accepting edge.
//
// Parameters
//   BIN_W  : binary input width, 1..9 (maximum input 511 fits three digits)
//
// Ports
//   clk    : system clock, all state updates on the rising edge
//   rst    : synchronous, active-high reset
//   start  : conversion request, honoured only in IDLE
//   bin    : binary value, captured on the accepting edge
//   busy   : high in SHIFT and DONE
//   done   : one-cycle pulse when a new result is loaded onto bcd
//   bcd    : registered result {hundreds, tens, ones}, each digit 0..9
// ---------------------------------------------------------------------------
module binary_to_bcd_sequential #(
    parameter int BIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [11:0]      bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] shift_q, shift_d;
    logic [11:0]      work_q,  work_d;
    logic [11:0]      bcd_q,   bcd_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;

    // Working digits after the add-3 correction.
    logic [11:0] work_adj;

    // {work, shift} shifted left by one as a single vector. The MSB of the
    // shift register falls into working bit 0. The bit shifted out of the
    // top is always zero for legal input widths.
    logic [BIN_W+11:0] dd_shifted;

    // A digit >= 5 becomes >= 10 after doubling. Adding 3 first makes the
    // doubled digit carry correctly into the next decade.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit_adj
            assign work_adj[gi*4 +: 4] = (work_q[gi*4 +: 4] >= 4'd5)
                                       ? work_q[gi*4 +: 4] + 4'd3
                                       : work_q[gi*4 +: 4];
        end
    endgenerate

    assign dd_shifted = {work_adj, shift_q} << 1;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = bin;
                    work_d  = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                work_d  = dd_shifted[BIN_W +: 12];
                shift_d = dd_shifted[BIN_W-1:0];
                cnt_d   = cnt_q + 1'b1;
                // The final shift goes straight to the output register, so
                // bcd changes only on the edge that raises done.
                if (cnt_q == LAST_CNT) begin
                    bcd_d   = dd_shifted[BIN_W +: 12];
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd_sequential.sv
// ---------------------------------------------------------------------------
// tb_binary_to_bcd_sequential
//
// Directed test of binary_to_bcd_sequential.
// Instances:
//   - u_dut8 : BIN_W = 8
//   - u_dut9 : BIN_W = 9
// Stimulus is applied 1 ns after a rising edge. Outputs are sampled at the
// same point.
// ---------------------------------------------------------------------------
module tb_binary_to_bcd_sequential;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start9;
    logic [7:0]  bin8;
    logic [8:0]  bin9;
    logic        busy8, done8, busy9, done9;
    logic [11:0] bcd8, bcd9;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] last_bcd8;

    always #5 clk = ~clk;

    binary_to_bcd_sequential #(.BIN_W(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .bcd   (bcd8)
    );

    binary_to_bcd_sequential #(.BIN_W(9)) u_dut9 (
        .clk   (clk),
        .rst   (rst),
        .start (start9),
        .bin   (bin9),
        .busy  (busy9),
        .done  (done9),
        .bcd   (bcd9)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Reference model: decimal digits obtained by division.
    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // Called 1 ns after a rising edge with the 8-bit DUT in IDLE.
    // When poke is set, a competing request (bin=45) is held on the inputs
    // during SHIFT.
    task automatic convert8(input int val, input logic [11:0] want, input bit poke, input string tag);
        int lat;
        int busy_cnt;
        bit hold_ok;
        logic [7:0] v8;
        v8 = val[7:0];
        start8 = 1'b1;
        bin8   = v8;
        @(posedge clk); #1;                      // accepting edge
        start8   = poke;
        bin8     = poke ? 8'd45 : ~v8;          // later bin changes must not matter
        lat      = 0;
        hold_ok  = 1'b1;
        busy_cnt = busy8 ? 1 : 0;
        while (!done8 && lat < 20) begin
            if (bcd8 !== last_bcd8) hold_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (busy8) busy_cnt++;
        end
        start8 = 1'b0;
        check({tag, "_latency"}, 16'(lat), 16'd8);
        check({tag, "_bcd"}, {4'h0, bcd8}, {4'h0, want});
        check({tag, "_hold"}, {15'd0, hold_ok}, 16'd1);
        @(posedge clk); #1;                      // DONE -> IDLE
        if (busy8) busy_cnt++;
        check({tag, "_done_width"}, {15'd0, done8}, 16'd0);
        check({tag, "_busy_cycles"}, 16'(busy_cnt), 16'd9);
        $display("conv8 %s bin=%0d bcd=%h expected=%h latency=%0d", tag, val, bcd8, want, lat);
        last_bcd8 = want;
    endtask

    task automatic convert9(input int val, input logic [11:0] want, input string tag);
        int lat;
        start9 = 1'b1;
        bin9   = val[8:0];
        @(posedge clk); #1;
        start9 = 1'b0;
        bin9   = '0;
        lat    = 0;
        while (!done9 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 16'(lat), 16'd9);
        check({tag, "_bcd"}, {4'h0, bcd9}, {4'h0, want});
        $display("conv9 %s bin=%0d bcd=%h expected=%h latency=%0d", tag, val, bcd9, want, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2;

        rst    = 1'b1;
        start8 = 1'b0;
        start9 = 1'b0;
        bin8   = '0;
        bin9   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy8", {15'd0, busy8}, 16'd0);
        check("rst_done8", {15'd0, done8}, 16'd0);
        check("rst_bcd8",  {4'h0, bcd8}, 16'h0000);
        check("rst_busy9", {15'd0, busy9}, 16'd0);
        check("rst_bcd9",  {4'h0, bcd9}, 16'h0000);
        $display("reset released");
        rst       = 1'b0;
        last_bcd8 = 12'h000;

        // Directed vectors with hand-computed results.
        convert8(0,   12'h000, 1'b0, "zero");
        convert8(255, 12'h255, 1'b0, "max");
        convert8(99,  12'h099, 1'b0, "ninetynine");
        convert8(10,  12'h010, 1'b0, "ten");
        convert8(123, 12'h123, 1'b1, "ignore_start");

        // Start held high: back-to-back conversions of 200 then 37.
        start8 = 1'b1;
        bin8   = 8'd200;
        d1     = -1;
        d2     = -1;
        for (int k = 0; k < 40 && d2 < 0; k++) begin
            @(posedge clk); #1;
            if (k == 0) bin8 = 8'd37;
            if (done8) begin
                if (d1 < 0) begin
                    d1 = k;
                    check("b2b_first_bcd", {4'h0, bcd8}, 16'h0200);
                end else begin
                    d2 = k;
                    check("b2b_second_bcd", {4'h0, bcd8}, 16'h0037);
                end
            end
        end
        start8 = 1'b0;
        check("b2b_first_latency", 16'(d1), 16'd8);
        check("b2b_spacing", 16'(d2 - d1), 16'd10);
        $display("b2b done pulses at cycles %0d and %0d", d1, d2);
        @(posedge clk); #1;
        last_bcd8 = 12'h037;

        // Reset on the 4th SHIFT edge aborts the conversion of 200.
        start8 = 1'b1;
        bin8   = 8'd200;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before_rst", {15'd0, busy8}, 16'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {15'd0, busy8}, 16'd0);
        check("abort_done", {15'd0, done8}, 16'd0);
        check("abort_bcd",  {4'h0, bcd8}, 16'h0000);
        $display("abort: busy=%b done=%b bcd=%h", busy8, done8, bcd8);
        rst       = 1'b0;
        last_bcd8 = 12'h000;
        // Request in the first cycle after reset release.
        convert8(99, 12'h099, 1'b0, "after_rst");

        // Exhaustive sweep against the division model.
        for (int v = 0; v < 256; v++) begin
            convert8(v, ref_bcd(v), 1'b0, "sweep");
        end

        // 9-bit instance.
        convert9(511, 12'h511, "w9_max");
        convert9(300, 12'h300, "w9_300");
        convert9(0,   12'h000, "w9_zero");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
